// File: rtl/dma_arbiter.sv
// Round-robin command arbiter for a shared MIG user port. Each granted transfer
// is split into bursts that never cross a MAX_BL-word boundary.
module dma_arbiter #(
  parameter int N_CH   = 4,
  parameter int ADDR_W = 30,
  parameter int LEN_W  = 16,
  parameter int MAX_BL = 64,
  localparam int ID_W  = $clog2(N_CH)
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic [N_CH-1:0]          req_i,
  input  logic [N_CH-1:0]          req_we_i,
  input  logic [N_CH*ADDR_W-1:0]   req_addr_i,
  input  logic [N_CH*LEN_W-1:0]    req_len_i,
  output logic [N_CH-1:0]          ack_o,
  output logic [N_CH-1:0]          done_o,
  output logic [N_CH-1:0]          len_err_o,
  output logic                     busy_o,
  output logic [ID_W-1:0]          grant_id_o,
  output logic                     cmd_en_o,
  output logic [2:0]               cmd_instr_o,
  output logic [5:0]               cmd_bl_o,
  output logic [ADDR_W-1:0]        cmd_byte_addr_o,
  input  logic                     cmd_full_i
);

  localparam int OFF_W = ($clog2(MAX_BL) > 0) ? $clog2(MAX_BL) : 1;

  typedef enum logic {S_IDLE = 1'b0, S_ISSUE = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [N_CH-1:0]   ack_q, len_err_q;
  logic [ID_W-1:0]   grant_q, last_q;
  logic              dir_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  rem_q;

  logic [LEN_W-1:0]  len_arr  [N_CH];
  logic [ADDR_W-1:0] addr_arr [N_CH];
  logic [ID_W-1:0]   sel, idx;
  logic              found, grant_ok;
  logic [LEN_W-1:0]  sel_len, room, burst;
  logic [ADDR_W-1:0] sel_addr;
  logic [OFF_W-1:0]  word_off;
  logic              last_burst, cmd_en;

  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      len_arr[i]  = req_len_i[i*LEN_W +: LEN_W];
      addr_arr[i] = req_addr_i[i*ADDR_W +: ADDR_W];
    end
  end

  // First requester found searching upward from the channel after the last grant.
  always_comb begin
    sel   = '0;
    idx   = '0;
    found = 1'b0;
    for (int i = 1; i <= N_CH; i++) begin
      idx = ID_W'((int'(last_q) + i) % N_CH);
      if (!found && req_i[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
  end

  // The ack cycle is never an arbitration cycle, so a requester still holding
  // req while it sees its ack cannot be granted twice.
  assign grant_ok = (state_q == S_IDLE) && found && !(|ack_q);
  assign sel_len  = len_arr[sel];
  assign sel_addr = addr_arr[sel];

  assign word_off   = addr_q[OFF_W+1:2] & OFF_W'(MAX_BL - 1);
  assign room       = LEN_W'(MAX_BL) - LEN_W'(word_off);
  assign burst      = (rem_q < room) ? rem_q : room;
  assign last_burst = (burst == rem_q);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (grant_ok && sel_len != '0) state_d = S_ISSUE;
      S_ISSUE: if (cmd_en && last_burst)      state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_en      = (state_q == S_ISSUE) && !cmd_full_i;
    done_o      = '0;
    cmd_bl_o    = '0;
    cmd_instr_o = 3'b000;
    if (cmd_en && last_burst) done_o[grant_q] = 1'b1;
    if (state_q == S_ISSUE) begin
      cmd_bl_o    = 6'(burst - LEN_W'(1));
      cmd_instr_o = {2'b00, ~dir_q};
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ack_q     <= '0;
      len_err_q <= '0;
      grant_q   <= '0;
      last_q    <= ID_W'(N_CH - 1);
      dir_q     <= 1'b0;
      addr_q    <= '0;
      rem_q     <= '0;
    end else begin
      ack_q     <= '0;
      len_err_q <= '0;
      if (grant_ok) begin
        ack_q[sel]     <= 1'b1;
        len_err_q[sel] <= (sel_len == '0);
        grant_q        <= sel;
        last_q         <= sel;
        dir_q          <= req_we_i[sel];
        addr_q         <= sel_addr & ~ADDR_W'(3);
        rem_q          <= sel_len;
      end else if (cmd_en) begin
        addr_q <= addr_q + ADDR_W'({burst, 2'b00});
        rem_q  <= rem_q - burst;
      end
    end
  end

  assign ack_o           = ack_q;
  assign len_err_o       = len_err_q;
  assign busy_o          = (state_q == S_ISSUE);
  assign grant_id_o      = grant_q;
  assign cmd_en_o        = cmd_en;
  assign cmd_byte_addr_o = addr_q;

endmodule

// File: tb/tb_dma_arbiter.sv
// Bench for dma_arbiter: directed scenarios with fixed expectations plus
// randomized rounds checked against a burst-list reference model.
module tb_dma_arbiter;
  localparam int N  = 4;
  localparam int AW = 30;
  localparam int LW = 16;
  localparam int MB = 64;
  localparam longint AMASK = 64'h3FFF_FFFF;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N-1:0]    req_i = '0, req_we_i = '0;
  logic [N*AW-1:0] req_addr_i = '0;
  logic [N*LW-1:0] req_len_i = '0;
  logic            cmd_full_i = 1'b0;
  logic [N-1:0]    ack_o, done_o, len_err_o;
  logic            busy_o, cmd_en_o;
  logic [1:0]      grant_id_o;
  logic [2:0]      cmd_instr_o;
  logic [5:0]      cmd_bl_o;
  logic [AW-1:0]   cmd_byte_addr_o;

  always #5 clk = ~clk;

  dma_arbiter #(.N_CH(N), .ADDR_W(AW), .LEN_W(LW), .MAX_BL(MB)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .req_i(req_i), .req_we_i(req_we_i),
    .req_addr_i(req_addr_i), .req_len_i(req_len_i), .ack_o(ack_o), .done_o(done_o),
    .len_err_o(len_err_o), .busy_o(busy_o), .grant_id_o(grant_id_o), .cmd_en_o(cmd_en_o),
    .cmd_instr_o(cmd_instr_o), .cmd_bl_o(cmd_bl_o), .cmd_byte_addr_o(cmd_byte_addr_o),
    .cmd_full_i(cmd_full_i));

  int total = 0;
  int bad = 0;

  int     t_we [N];
  longint t_addr [N];
  int     t_len [N];

  int b_bl[$], b_instr[$], b_gid[$], b_done[$], b_cyc[$];
  longint b_addr[$];
  int a_id[$], a_cyc[$], a_le[$];
  int o_busy[$], o_full[$], o_en[$], o_bl[$];
  longint o_addr[$];
  int le_cnt, stray_done;

  int e_bl[$], e_instr[$], e_gid[$], e_done[$], e_id[$], e_le[$];
  longint e_addr[$];
  int model_last;

  task automatic load_ch(input int ch, input int we, input longint addr, input int len);
    t_we[ch] = we; t_addr[ch] = addr & AMASK; t_len[ch] = len;
    req_we_i[ch] = (we != 0);
    req_addr_i[ch*AW +: AW] = AW'(addr);
    req_len_i[ch*LW +: LW] = LW'(len);
  endtask

  task automatic apply_reset;
    rst_n = 1'b0; req_i = '0; cmd_full_i = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_last = N - 1;
  endtask

  // Drives req=mask for one cycle window, emulates requesters dropping req on
  // ack, applies cmd_full (window and/or random percent) and records outputs.
  task automatic collect(input logic [N-1:0] mask, input int ncyc, input int st_at,
                         input int st_len, input int st_pct);
    b_bl.delete(); b_instr.delete(); b_gid.delete(); b_done.delete(); b_cyc.delete(); b_addr.delete();
    a_id.delete(); a_cyc.delete(); a_le.delete();
    o_busy.delete(); o_full.delete(); o_en.delete(); o_bl.delete(); o_addr.delete();
    le_cnt = 0; stray_done = 0;
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clk); #1;
      if (c == 0) req_i = mask;
      cmd_full_i = (c >= st_at && c < st_at + st_len) ||
                   (st_pct > 0 && $urandom_range(0, 99) < st_pct);
      @(negedge clk);
      o_busy.push_back(int'(busy_o)); o_full.push_back(int'(cmd_full_i));
      o_en.push_back(int'(cmd_en_o)); o_bl.push_back(int'(cmd_bl_o));
      o_addr.push_back(longint'(cmd_byte_addr_o));
      if (cmd_en_o) begin
        b_bl.push_back(int'(cmd_bl_o)); b_addr.push_back(longint'(cmd_byte_addr_o));
        b_instr.push_back(int'(cmd_instr_o)); b_gid.push_back(int'(grant_id_o));
        b_done.push_back(int'(done_o)); b_cyc.push_back(c);
      end else if (done_o != '0) stray_done++;
      for (int i = 0; i < N; i++)
        if (ack_o[i]) begin a_id.push_back(i); a_cyc.push_back(c); a_le.push_back(int'(len_err_o[i])); end
      if (len_err_o != '0) le_cnt++;
      req_i = req_i & ~ack_o;
    end
    cmd_full_i = 1'b0;
  endtask

  // Expected grant order and burst list from the arbitration and split rules.
  task automatic model_build(input logic [N-1:0] mask);
    logic [N-1:0] pend;
    int pick, ch, rem, room, b;
    longint a;
    e_bl.delete(); e_instr.delete(); e_gid.delete(); e_done.delete(); e_id.delete(); e_le.delete(); e_addr.delete();
    pend = mask;
    while (pend != '0) begin
      pick = -1;
      for (int k = 1; k <= N; k++) begin
        ch = (model_last + k) % N;
        if (pick < 0 && pend[ch]) pick = ch;
      end
      pend[pick] = 1'b0; model_last = pick;
      e_id.push_back(pick); e_le.push_back(int'(t_len[pick] == 0));
      rem = t_len[pick]; a = t_addr[pick] & ~64'h3;
      while (rem > 0) begin
        room = MB - int'((a >> 2) % MB);
        b = (rem < room) ? rem : room;
        e_bl.push_back(b - 1); e_addr.push_back(a);
        e_instr.push_back(t_we[pick] != 0 ? 0 : 1); e_gid.push_back(pick);
        e_done.push_back(rem == b ? (1 << pick) : 0);
        a = (a + 4 * b) & AMASK; rem -= b;
      end
    end
  endtask

  task automatic test_reset;
    apply_reset();
    total++; if (ack_o !== '0)     begin bad++; $display("FAIL reset_ack: got %0h want 0", ack_o); end
    total++; if (done_o !== '0)    begin bad++; $display("FAIL reset_done: got %0h want 0", done_o); end
    total++; if (len_err_o !== '0) begin bad++; $display("FAIL reset_len_err: got %0h want 0", len_err_o); end
    total++; if (busy_o !== 1'b0)  begin bad++; $display("FAIL reset_busy: got %0b want 0", busy_o); end
    total++; if (cmd_en_o !== 1'b0) begin bad++; $display("FAIL reset_cmd_en: got %0b want 0", cmd_en_o); end
    total++; if (grant_id_o !== '0) begin bad++; $display("FAIL reset_grant_id: got %0d want 0", grant_id_o); end
    total++; if (cmd_bl_o !== '0 || cmd_byte_addr_o !== '0)
      begin bad++; $display("FAIL reset_cmd_fields: got bl %0d addr %0h want 0 0", cmd_bl_o, cmd_byte_addr_o); end
  endtask

  task automatic test_read;
    load_ch(1, 0, 0, 10);
    collect(4'b0010, 6, 1000, 0, 0);
    total++; if (a_id.size() != 1 || a_id[0] != 1) begin bad++; $display("FAIL read_ack: got n=%0d id=%0d want n=1 id=1", a_id.size(), a_id[0]); end
    total++; if (a_cyc[0] != 1) begin bad++; $display("FAIL read_ack_cycle: got %0d want 1", a_cyc[0]); end
    total++; if (b_bl.size() != 1) begin bad++; $display("FAIL read_bursts: got %0d want 1", b_bl.size()); end
    else begin
      total++; if (b_bl[0] != 9 || b_addr[0] != 0 || b_instr[0] != 1)
        begin bad++; $display("FAIL read_cmd: got bl %0d addr %0h instr %0d want 9 0 1", b_bl[0], b_addr[0], b_instr[0]); end
      total++; if (b_done[0] != 2 || b_cyc[0] != 1)
        begin bad++; $display("FAIL read_done: got done %0h cyc %0d want 2 1", b_done[0], b_cyc[0]); end
    end
    total++; if (o_busy[0] != 0 || o_busy[1] != 1 || o_busy[2] != 0)
      begin bad++; $display("FAIL read_busy: got %0d%0d%0d want 010", o_busy[0], o_busy[1], o_busy[2]); end
  endtask

  task automatic test_write_split;
    int xbl [3];
    longint xad [3];
    xbl = '{63, 63, 21}; xad = '{64'h000, 64'h100, 64'h200};
    load_ch(0, 1, 0, 150);
    collect(4'b0001, 8, 1000, 0, 0);
    total++; if (b_bl.size() != 3) begin bad++; $display("FAIL split_bursts: got %0d want 3", b_bl.size()); end
    else for (int i = 0; i < 3; i++) begin
      total++; if (b_bl[i] != xbl[i] || b_addr[i] != xad[i] || b_instr[i] != 0 || b_cyc[i] != i + 1)
        begin bad++; $display("FAIL split_burst%0d: got bl %0d addr %0h instr %0d cyc %0d want %0d %0h 0 %0d", i, b_bl[i], b_addr[i], b_instr[i], b_cyc[i], xbl[i], xad[i], i + 1); end
      total++; if (b_done[i] != (i == 2 ? 1 : 0))
        begin bad++; $display("FAIL split_done%0d: got %0h want %0h", i, b_done[i], (i == 2 ? 1 : 0)); end
    end
    total++; if (o_busy[3] != 1 || o_busy[4] != 0)
      begin bad++; $display("FAIL split_busy: got %0d%0d want 10", o_busy[3], o_busy[4]); end
  endtask

  task automatic test_boundary;
    load_ch(2, 0, 64'hF0, 20);
    collect(4'b0100, 6, 1000, 0, 0);
    total++; if (b_bl.size() != 2) begin bad++; $display("FAIL bound_bursts: got %0d want 2", b_bl.size()); end
    else begin
      total++; if (b_bl[0] != 3 || b_addr[0] != 64'hF0)
        begin bad++; $display("FAIL bound_first: got bl %0d addr %0h want 3 f0", b_bl[0], b_addr[0]); end
      total++; if (b_bl[1] != 15 || b_addr[1] != 64'h100 || b_done[1] != 4)
        begin bad++; $display("FAIL bound_second: got bl %0d addr %0h done %0h want 15 100 4", b_bl[1], b_addr[1], b_done[1]); end
    end
  endtask

  task automatic test_backpressure;
    load_ch(3, 1, 0, 150);
    collect(4'b1000, 12, 2, 5, 0);
    total++; if (b_bl.size() != 3) begin bad++; $display("FAIL bp_bursts: got %0d want 3", b_bl.size()); end
    else begin
      total++; if (b_cyc[0] != 1 || b_cyc[1] != 7 || b_cyc[2] != 8)
        begin bad++; $display("FAIL bp_cycles: got %0d %0d %0d want 1 7 8", b_cyc[0], b_cyc[1], b_cyc[2]); end
      total++; if (b_bl[1] != 63 || b_addr[1] != 64'h100 || b_bl[2] != 21 || b_done[2] != 8)
        begin bad++; $display("FAIL bp_resume: got bl %0d addr %0h bl %0d done %0h want 63 100 21 8", b_bl[1], b_addr[1], b_bl[2], b_done[2]); end
    end
    for (int c = 2; c < 7; c++) begin
      total++; if (o_en[c] != 0 || o_bl[c] != 63 || o_addr[c] != 64'h100 || o_busy[c] != 1)
        begin bad++; $display("FAIL bp_stall_c%0d: got en %0d bl %0d addr %0h busy %0d want 0 63 100 1", c, o_en[c], o_bl[c], o_addr[c], o_busy[c]); end
    end
  endtask

  task automatic test_len0;
    load_ch(1, 0, 64'h80, 0);
    load_ch(2, 0, 64'h40, 5);
    collect(4'b0110, 8, 1000, 0, 0);
    total++; if (a_id.size() != 2) begin bad++; $display("FAIL len0_acks: got %0d want 2", a_id.size()); end
    else begin
      total++; if (a_id[0] != 1 || a_le[0] != 1 || a_id[1] != 2 || a_le[1] != 0)
        begin bad++; $display("FAIL len0_order: got %0d/%0d %0d/%0d want 1/1 2/0", a_id[0], a_le[0], a_id[1], a_le[1]); end
    end
    total++; if (le_cnt != 1) begin bad++; $display("FAIL len0_pulse: got %0d cycles want 1", le_cnt); end
    total++; if (b_bl.size() != 1 || b_bl[0] != 4 || b_addr[0] != 64'h40 || b_gid[0] != 2 || b_cyc[0] != 3)
      begin bad++; $display("FAIL len0_next: got n %0d bl %0d addr %0h gid %0d cyc %0d want 1 4 40 2 3", b_bl.size(), b_bl[0], b_addr[0], b_gid[0], b_cyc[0]); end
  endtask

  task automatic test_round_robin;
    apply_reset();
    for (int i = 0; i < N; i++) load_ch(i, i % 2, 64'h1000 * i, 1);
    collect(4'b1111, 12, 1000, 0, 0);
    total++; if (a_id.size() != 4) begin bad++; $display("FAIL rr_acks: got %0d want 4", a_id.size()); end
    else for (int i = 0; i < 4; i++) begin
      total++; if (a_id[i] != i || a_cyc[i] != 2 * i + 1)
        begin bad++; $display("FAIL rr_grant%0d: got id %0d cyc %0d want %0d %0d", i, a_id[i], a_cyc[i], i, 2 * i + 1); end
    end
    total++; if (b_done.size() != 4 || b_done[3] != 8 || b_gid[3] != 3)
      begin bad++; $display("FAIL rr_done: got n %0d done %0h gid %0d want 4 8 3", b_done.size(), b_done[3], b_gid[3]); end
    collect(4'b0101, 8, 1000, 0, 0);
    total++; if (a_id.size() != 2 || a_id[0] != 0 || a_id[1] != 2)
      begin bad++; $display("FAIL rr_rerequest: got n %0d %0d %0d want 2 0 2", a_id.size(), a_id[0], a_id[1]); end
  endtask

  task automatic test_reset_mid;
    int seen, dn;
    seen = 0; dn = 0;
    load_ch(0, 1, 0, 150);
    @(posedge clk); #1; req_i = 4'b0001;
    for (int c = 0; c < 10 && seen == 0; c++) begin
      @(negedge clk);
      if (done_o != '0) dn++;
      if (cmd_en_o) seen++;
      req_i = req_i & ~ack_o;
    end
    total++; if (seen != 1 || dn != 0) begin bad++; $display("FAIL rstmid_first: got bursts %0d done %0d want 1 0", seen, dn); end
    @(posedge clk); #1;
    total++; if (cmd_en_o !== 1'b1 || cmd_byte_addr_o !== 30'h100)
      begin bad++; $display("FAIL rstmid_second: got en %0b addr %0h want 1 100", cmd_en_o, cmd_byte_addr_o); end
    rst_n = 1'b0; #1;
    total++; if (cmd_en_o !== 1'b0 || busy_o !== 1'b0 || done_o !== '0 || ack_o !== '0 || len_err_o !== '0)
      begin bad++; $display("FAIL rstmid_ctrl: got en %0b busy %0b done %0h ack %0h le %0h want all 0", cmd_en_o, busy_o, done_o, ack_o, len_err_o); end
    total++; if (grant_id_o !== '0 || cmd_bl_o !== '0 || cmd_byte_addr_o !== '0 || cmd_instr_o !== '0)
      begin bad++; $display("FAIL rstmid_fields: got gid %0d bl %0d addr %0h instr %0d want all 0", grant_id_o, cmd_bl_o, cmd_byte_addr_o, cmd_instr_o); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1; model_last = N - 1;
    load_ch(0, 0, 64'h400, 1);
    load_ch(1, 0, 64'h800, 1);
    collect(4'b0011, 8, 1000, 0, 0);
    total++; if (a_id.size() != 2 || a_id[0] != 0 || a_id[1] != 1)
      begin bad++; $display("FAIL rstmid_rr: got n %0d %0d %0d want 2 0 1", a_id.size(), a_id[0], a_id[1]); end
  endtask

  task automatic test_random;
    logic [N-1:0] mask;
    int budget, viol;
    apply_reset();
    for (int r = 0; r < 25; r++) begin
      mask = N'($urandom_range(1, (1 << N) - 1));
      for (int i = 0; i < N; i++)
        load_ch(i, int'($urandom_range(0, 1)), longint'($urandom) & AMASK,
                ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 200)));
      if (r == 0) begin mask[0] = 1'b1; load_ch(0, 1, 64'h3FFF_FFF8, 5); end
      model_build(mask);
      budget = 3 * (e_bl.size() + 2 * e_id.size()) + 20;
      collect(mask, budget, 1000, 0, int'($urandom_range(0, 25)));
      total++; if (a_id.size() != e_id.size() || b_bl.size() != e_bl.size())
        begin bad++; $display("FAIL rnd%0d_counts: got acks %0d bursts %0d want %0d %0d", r, a_id.size(), b_bl.size(), e_id.size(), e_bl.size()); end
      else begin
        for (int i = 0; i < e_id.size(); i++) begin
          total++; if (a_id[i] != e_id[i] || a_le[i] != e_le[i])
            begin bad++; $display("FAIL rnd%0d_grant%0d: got %0d/%0d want %0d/%0d", r, i, a_id[i], a_le[i], e_id[i], e_le[i]); end
        end
        for (int i = 0; i < e_bl.size(); i++) begin
          total++; if (b_bl[i] != e_bl[i] || b_addr[i] != e_addr[i] || b_instr[i] != e_instr[i] ||
                       b_gid[i] != e_gid[i] || b_done[i] != e_done[i])
            begin bad++; $display("FAIL rnd%0d_burst%0d: got bl %0d addr %0h instr %0d gid %0d done %0h want %0d %0h %0d %0d %0h", r, i, b_bl[i], b_addr[i], b_instr[i], b_gid[i], b_done[i], e_bl[i], e_addr[i], e_instr[i], e_gid[i], e_done[i]); end
        end
      end
      viol = stray_done;
      for (int c = 0; c < o_en.size(); c++) if (o_full[c] != 0 && o_en[c] != 0) viol++;
      total++; if (viol != 0) begin bad++; $display("FAIL rnd%0d_full_or_stray_done: got %0d events want 0", r, viol); end
      total++; if (o_busy[o_busy.size() - 1] != 0 || req_i != '0)
        begin bad++; $display("FAIL rnd%0d_idle_at_end: got busy %0d req %0h want 0 0", r, o_busy[o_busy.size() - 1], req_i); end
    end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write_split();
    test_boundary();
    test_backpressure();
    test_len0();
    test_round_robin();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dma_arbiter.md
# dma_arbiter

Parametrised command arbiter that lets N compute cores (conv_1x1, conv_3x3, pool_3x3, pool_13x13, …) share one MIG user port. It accepts per-channel transfer requests, grants them round-robin, splits each transfer into MIG bursts that never cross a MAX_BL-word boundary, and drives the MIG command interface. It sits between csb/the cores and the memc3 p0/p1 command port, replacing the single-requester command path in dma. It carries no data path; data FIFOs are handled per core.

## Interface
- N_CH, 4, number of requesting channels (2..8)
- ADDR_W, 30, byte-address width
- LEN_W, 16, transfer-length width in 32-bit words
- MAX_BL, 64, maximum burst in words (power of 2, ≤64)
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- req  in  N_CH  per-channel request; held high until ack
- req_we  in  N_CH  1 = write, 0 = read
- req_addr  in  N_CH*ADDR_W  start byte address; bits [1:0] ignored
- req_len  in  N_CH*LEN_W  length in words; 0 is illegal
- ack  out  N_CH  one-cycle pulse: request latched (or rejected)
- done  out  N_CH  one-cycle pulse with the final burst's cmd_en
- len_err  out  N_CH  one-cycle pulse: request rejected, len = 0
- busy  out  1  high while not IDLE
- grant_id  out  $clog2(N_CH)  channel being served
- cmd_en  out  1  MIG command strobe
- cmd_instr  out  3  3'b000 write, 3'b001 read
- cmd_bl  out  6  burst length − 1
- cmd_byte_addr  out  ADDR_W  burst start byte address
- cmd_full  in  1  MIG command FIFO full

## Operation
- States: IDLE, ISSUE.
- IDLE: if any req bit is set, select the first set bit searching upward from (last_grant+1) mod N_CH. Next edge: pulse ack[sel], load grant_id, dir, addr (low 2 bits cleared), remaining = len, last_grant = sel.
  - If len == 0: also pulse len_err[sel], stay IDLE, issue no command.
  - Otherwise go to ISSUE.
- ISSUE: burst = min(remaining, MAX_BL − word_addr mod MAX_BL), where word_addr = addr>>2.
  - cmd_bl = burst−1, cmd_byte_addr = addr, cmd_instr from dir. All are combinational from registers.
  - cmd_en = ISSUE & ~cmd_full (combinational).
  - On each edge with cmd_en: addr += burst*4, remaining −= burst.
  - If burst == remaining: done[grant_id] pulses in the same cycle as that cmd_en, and the next state is IDLE.
- While cmd_full is high, cmd_en = 0 and all cmd_* fields hold their values.
- req is sampled only in IDLE. req bits that rise during ISSUE wait for arbitration.
- Address arithmetic wraps modulo 2^ADDR_W. remaining never underflows.
- Reset values: ack, done, len_err, busy, cmd_en = 0; grant_id = 0; last_grant = N_CH−1, so channel 0 wins first. Internal address and length registers reset to 0.
- Reset mid-transfer: the state returns to IDLE immediately. The partial transfer is abandoned with no done; the requester re-requests.

## Timing
- req high at edge t (IDLE) → ack at t+1. First cmd_en can occur in cycle t+1 if cmd_full is low.
- One burst per cycle while cmd_full is low. An N-burst transfer occupies ISSUE for N cycles plus stall cycles.
- After done, at least one IDLE cycle precedes the next grant. Arbitration throughput is therefore bursts+1 cycles per request.
- busy is registered: high from t+1 through the cycle of the final cmd_en.
- ack and len_err are registered pulses, exactly one cycle wide.

## Test plan
- Read, ch1, addr 0x0, len 10 → ack[1]; one cmd_en with instr 001, bl 9, addr 0x0; done[1] in the same cycle.
- Write, ch0, addr 0x0, len 150, MAX_BL 64 → bursts bl 63/63/21 at addrs 0x000/0x100/0x200, instr 000; done[0] on the third burst.
- Boundary split: addr 0xF0, len 20 → bursts bl 3 at 0xF0, then bl 15 at 0x100.
- Round-robin: req = 4'b1111 at once, each len 1 → grants 0,1,2,3. Then ch0 and ch2 re-request → ch0, then ch2. No channel is granted twice while another is pending.
- Back-pressure: cmd_full high for 5 cycles mid-transfer → cmd_en low, cmd_bl and cmd_byte_addr stable; issuing resumes with the same burst.
- Edge cases:
  - req with len 0 → ack and len_err pulse together; no cmd_en; the next requester is served.
  - rst_n low during the second burst of a len-150 transfer → all outputs 0 at once, no done; after release, ch0 wins first.
